dpram_bex: RTL

- Parametrised true dual-port synchronous RAM with per-lane byte enables, write-collision resolution and a built-in clear sequencer.
- Successor to the plain 8-bit dual-port RAM used for VRAM/sprite memory in the epochtv1 video path.
- Memory clears itself after reset, and again on request, so video logic never reads stale contents.

---
 rtl/dpram_bex_pkg.sv | 31 +++
 rtl/dpram_bex_clrseq.sv | 70 +++++++
 rtl/dpram_bex.sv | 129 ++++++++++++
 3 files changed

// File: rtl/dpram_bex_pkg.sv
// Shared types and the lane-merge helper for the byte-enabled dual-port RAM.
// Optional second output register stage is enabled by DPRAM_BEX_OREG_EN.
package dpram_bex_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam int MAX_DW    = 256;
  localparam int MAX_LANES = 32;

  // Lanes with be=1 take new_w, all other bits keep old_w; widths are padded to the maxima.
  function automatic logic [MAX_DW-1:0] lane_merge(
    input logic [MAX_DW-1:0]    old_w,
    input logic [MAX_DW-1:0]    new_w,
    input logic [MAX_LANES-1:0] be,
    input int                   lanes,
    input int                   dwidth
  );
    logic [MAX_DW-1:0] res;
    int lane_w;
    res    = old_w;
    lane_w = dwidth / lanes;
    for (int b = 0; b < MAX_DW; b++) begin
      if (b < dwidth && be[5'(b / lane_w)]) res[8'(b)] = new_w[8'(b)];
    end
    return res;
  endfunction

endpackage

// File: rtl/dpram_bex_clrseq.sv
// Clear sequencer: owns port A's write path while sweeping CLR_VAL through the array.
module dpram_bex_clrseq
  import dpram_bex_pkg::*;
#(
  parameter int                AWIDTH  = 10,
  parameter int                DWIDTH  = 16,
  parameter int                LANES   = 2,
  parameter logic [DWIDTH-1:0] CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              we_a,
  input  logic [AWIDTH-1:0] addr_a,
  input  logic [DWIDTH-1:0] din_a,
  input  logic [LANES-1:0]  be_a,
  output logic              busy,
  output logic              wr_en,
  output logic [AWIDTH-1:0] wr_addr,
  output logic [DWIDTH-1:0] wr_data,
  output logic [LANES-1:0]  wr_be
);

  state_t          state, state_next;
  logic [AWIDTH:0] cnt, cnt_next, cnt_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Counter MSB going high after the last address hands the array back to the ports.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cnt_inc    = cnt + (AWIDTH + 1)'(1);
    wr_en      = we_a;
    wr_addr    = addr_a;
    wr_data    = din_a;
    wr_be      = be_a;
    case (state)
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = cnt[AWIDTH-1:0];
        wr_data = CLR_VAL;
        wr_be   = '1;
        if (clr) begin
          cnt_next = '0;
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc[AWIDTH]) state_next = IDLE;
        end
      end
      IDLE: begin
        if (clr) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
    endcase
  end

  assign busy = (state == CLEAR);

endmodule

// File: rtl/dpram_bex.sv
// True dual-port RAM with lane enables, collision merge and self-clear.
// Define DPRAM_BEX_OREG_EN for a second output register stage (2-cycle read latency).
module dpram_bex
  import dpram_bex_pkg::*;
#(
  parameter int                DWIDTH  = 16,
  parameter int                AWIDTH  = 10,
  parameter int                LANES   = 2,
  parameter int                RDW_NEW = 0,
  parameter logic [DWIDTH-1:0] CLR_VAL = '0
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              CLR,
  output logic              BUSY,
  output logic              COLL,
  input  logic              nCE,
  input  logic              nWE,
  input  logic              nOE,
  input  logic [AWIDTH-1:0] A,
  input  logic [DWIDTH-1:0] DI,
  input  logic [LANES-1:0]  BE,
  output logic [DWIDTH-1:0] DO,
  input  logic              nCE2,
  input  logic              nWE2,
  input  logic              nOE2,
  input  logic [AWIDTH-1:0] A2,
  input  logic [DWIDTH-1:0] DI2,
  input  logic [LANES-1:0]  BE2,
  output logic [DWIDTH-1:0] DO2
);

  localparam int DEPTH = 1 << AWIDTH;

  logic [DWIDTH-1:0] mem [DEPTH];

  logic              busy, wa_en, wr_a_req, wr_b, rd_a, rd_b, same_wr, coll_next;
  logic [AWIDTH-1:0] wa_addr;
  logic [DWIDTH-1:0] wa_data, word_a, word_b, rdata_a, rdata_b;
  logic [DWIDTH-1:0] do_a1, do_b1;
  logic [LANES-1:0]  wa_be;
  logic              coll_q;

  function automatic logic [DWIDTH-1:0] merge(
    input logic [DWIDTH-1:0] old_w,
    input logic [DWIDTH-1:0] new_w,
    input logic [LANES-1:0]  be
  );
    return DWIDTH'(lane_merge(MAX_DW'(old_w), MAX_DW'(new_w), MAX_LANES'(be), LANES, DWIDTH));
  endfunction

  assign wr_a_req = ~(nCE | nWE);

  dpram_bex_clrseq #(
    .AWIDTH (AWIDTH),
    .DWIDTH (DWIDTH),
    .LANES  (LANES),
    .CLR_VAL(CLR_VAL)
  ) u_clrseq (
    .clk    (CLK),
    .rst_n  (nRST),
    .clr    (CLR),
    .we_a   (wr_a_req),
    .addr_a (A),
    .din_a  (DI),
    .be_a   (BE),
    .busy   (busy),
    .wr_en  (wa_en),
    .wr_addr(wa_addr),
    .wr_data(wa_data),
    .wr_be  (wa_be)
  );

  // On a same-address double write, port A's merge is layered over port B's so A wins overlaps.
  always_comb begin
    rd_a      = ~(nCE | nOE) & ~busy;
    rd_b      = ~(nCE2 | nOE2) & ~busy;
    wr_b      = ~(nCE2 | nWE2) & ~busy;
    same_wr   = wa_en & wr_b & (wa_addr == A2);
    coll_next = same_wr & (|(wa_be & BE2));
    word_b    = merge(mem[A2], DI2, BE2);
    word_a    = merge(same_wr ? word_b : mem[wa_addr], wa_data, wa_be);
    rdata_a   = (RDW_NEW != 0 && wr_a_req) ? merge(mem[A], DI, BE) : mem[A];
    rdata_b   = (RDW_NEW != 0 && wr_b) ? merge(mem[A2], DI2, BE2) : mem[A2];
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      if (wr_b && !same_wr) mem[A2] <= word_b;
      if (wa_en) mem[wa_addr] <= word_a;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      do_a1  <= '0;
      do_b1  <= '0;
      coll_q <= 1'b0;
    end else begin
      if (rd_a) do_a1 <= rdata_a;
      if (rd_b) do_b1 <= rdata_b;
      coll_q <= coll_next;
    end
  end

`ifdef DPRAM_BEX_OREG_EN
  logic [DWIDTH-1:0] do_a2, do_b2;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      do_a2 <= '0;
      do_b2 <= '0;
    end else begin
      do_a2 <= do_a1;
      do_b2 <= do_b1;
    end
  end

  assign DO  = do_a2;
  assign DO2 = do_b2;
`else
  assign DO  = do_a1;
  assign DO2 = do_b1;
`endif

  assign BUSY = busy;
  assign COLL = coll_q;

endmodule
